// File: rtl/sorter_writeback_stream_buffer_if.sv
// Stream handshake bundle carrying merged words from the merge network
// into the writeback buffer. The producer drives data/valid, the consumer
// answers with ready.
interface axi_stream #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sorter_writeback_stream_buffer.sv
// Sorter writeback stage with an internal circular FIFO. Merged words are
// buffered as they arrive, and on start a chunk of them is written into the
// result memory, ascending or descending from a base address. The stage
// stalls whenever the buffer runs dry.
module sorter_writeback_stream_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         chunk_size,
  input  logic [ADDR_WIDTH-1:0]         base_address,
  input  logic                          descending,
  axi_stream.slave                      input_data,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [ADDR_WIDTH-1:0]         write_addr,
  output logic                          write_enable,
  output logic                          busy,
  output logic                          writeback_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITING, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic                  full, empty, push, pop, accept, last_word;
  logic [ADDR_WIDTH-1:0] chunk_reg, base_reg, offset;
  logic                  desc_reg;

  // The extra pointer bit tells a full buffer apart from an empty one.
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = input_data.valid && !full;

  assign input_data.ready = !full;
  assign fifo_level       = wr_ptr - rd_ptr;
  assign last_word        = (offset == chunk_reg - ADDR_WIDTH'(1));

  // Next-state logic: accept start only when fully idle, pop whenever writing with data.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !busy) begin
          accept     = 1'b1;
          state_next = (chunk_size == '0) ? DONE : WRITING;
        end
      end
      WRITING: begin
        if (!empty) begin
          pop = 1'b1;
          if (last_word) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Buffer storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= input_data.data;
  end

  // Buffer pointers; push and pop in the same cycle both take effect.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Writeback datapath: latch the job on start, register each popped word with its address.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable   <= 1'b0;
      write_addr     <= '0;
      write_data     <= '0;
      writeback_done <= 1'b0;
      busy           <= 1'b0;
      chunk_reg      <= '0;
      base_reg       <= '0;
      desc_reg       <= 1'b0;
      offset         <= '0;
    end else begin
      write_enable   <= pop;
      writeback_done <= (state == DONE);
      if (accept) begin
        chunk_reg <= chunk_size;
        base_reg  <= base_address;
        desc_reg  <= descending;
        offset    <= '0;
        busy      <= 1'b1;
      end else if (writeback_done) begin
        busy <= 1'b0;
      end
      if (pop) begin
        write_data <= mem[rd_ptr[PTR_W-1:0]];
        write_addr <= desc_reg ? (base_reg + chunk_reg - ADDR_WIDTH'(1) - offset)
                               : (base_reg + offset);
        offset     <= offset + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_sorter_writeback_stream_buffer.sv
// Self-checking bench for the sorter writeback stream buffer. Every pushed
// word goes into a data queue and every accepted writeback expands into a
// queue of expected addresses; a negedge monitor pops both on each memory
// write and also checks the done pulse timing.
module tb_sorter_writeback_stream_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] chunk_size = '0;
  logic [15:0] base_address = '0;
  logic        descending = 1'b0;
  logic [31:0] write_data;
  logic [15:0] write_addr;
  logic        write_enable;
  logic        busy;
  logic        writeback_done;
  logic [5:0]  fifo_level;

  axi_stream #(.DATA_WIDTH(32)) sif ();

  sorter_writeback_stream_buffer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .FIFO_DEPTH(32)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .chunk_size(chunk_size), .base_address(base_address),
    .descending(descending), .input_data(sif),
    .write_data(write_data), .write_addr(write_addr),
    .write_enable(write_enable), .busy(busy),
    .writeback_done(writeback_done), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int failures = 0;
  int cycle = 0;

  logic [31:0] data_q[$];
  int          pcyc_q[$];
  logic [15:0] addr_q[$];

  int done_seen = 0;
  int exp_done = 0;
  int start_cycle = 0;
  int run_chunk = 0;
  int run_writes = 0;
  int first_we = 0;
  int last_we = 0;
  bit stall_check = 0;
  bit prev_done = 0;

  // Cycle counter; constant between posedges, read at negedges.
  always @(posedge clock) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    tests++;
    failures++;
    $display("[TB] FAIL %s: event did not occur as required", name);
  endtask

  // Drive n words; gap idle cycles between words. Words are random or count up from first.
  task automatic send_words(input int n, input int gap, input bit rnd, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      int t;
      d = rnd ? $urandom : first + 32'(i);
      t = 0;
      @(negedge clock);
      sif.valid = 1'b1;
      sif.data  = d;
      while (!sif.ready && t < 300) begin
        @(negedge clock);
        t++;
      end
      if (t >= 300) begin
        reportFail("push_timeout");
        sif.valid = 1'b0;
        return;
      end
      data_q.push_back(d);
      pcyc_q.push_back(cycle);
      if (gap > 0) begin
        @(negedge clock);
        sif.valid = 1'b0;
        repeat (gap - 1) @(negedge clock);
      end
    end
    @(negedge clock);
    sif.valid = 1'b0;
  endtask

  // Issue one start pulse and expand the job into its expected address sequence.
  task automatic applyStimulus(input int chunk, input logic [15:0] base, input bit desc);
    @(negedge clock);
    start        = 1'b1;
    chunk_size   = 16'(chunk);
    base_address = base;
    descending   = desc;
    start_cycle  = cycle;
    run_chunk    = chunk;
    run_writes   = 0;
    for (int i = 0; i < chunk; i++)
      addr_q.push_back(desc ? 16'(base + 16'(chunk - 1 - i)) : 16'(base + 16'(i)));
    exp_done++;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Bounded wait for the expected done pulse, then confirm all writes happened.
  task automatic wait_done();
    int t = 0;
    while (done_seen < exp_done && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 2000) reportFail("done_timeout");
    @(negedge clock);
    checkOutput("pending_writes", 64'(addr_q.size()), 0);
  endtask

  // Latency and contiguity of a run whose data was buffered before start.
  task automatic check_run(input int chunk);
    checkOutput("first_write_latency", 64'(first_we), 64'(start_cycle + 2));
    checkOutput("contiguous_writes", 64'(last_we - first_we), 64'(chunk - 1));
  endtask

  // Monitor: compare every memory write and done pulse against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      prev_done = 0;
    end else begin
      if (prev_done) checkOutput("busy_after_done", 64'(busy), 0);
      prev_done = writeback_done;
      if (write_enable) begin
        if (addr_q.size() == 0 || data_q.size() == 0) begin
          reportFail("unexpected_write");
        end else begin
          logic [15:0] ea;
          logic [31:0] ed;
          int pc;
          ea = addr_q.pop_front();
          ed = data_q.pop_front();
          pc = pcyc_q.pop_front();
          checkOutput("write_addr", 64'(write_addr), 64'(ea));
          checkOutput("write_data", 64'(write_data), 64'(ed));
          if (stall_check) checkOutput("stall_latency", 64'(cycle), 64'(pc + 2));
        end
        if (run_writes == 0) first_we = cycle;
        last_we = cycle;
        run_writes++;
      end
      if (writeback_done) begin
        done_seen++;
        checkOutput("busy_at_done", 64'(busy), 1);
        if (run_chunk == 0) checkOutput("done_latency_zero", 64'(cycle), 64'(start_cycle + 2));
        else                checkOutput("done_latency", 64'(cycle), 64'(last_we + 1));
      end
    end
  end

  initial begin
    sif.valid = 1'b0;
    sif.data  = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_write_enable", 64'(write_enable), 0);
    checkOutput("reset_busy", 64'(busy), 0);
    checkOutput("reset_level", 64'(fifo_level), 0);
    checkOutput("reset_ready", 64'(sif.ready), 1);
    reset = 1'b0;

    // Ascending basic.
    send_words(8, 0, 0, 32'h10);
    applyStimulus(8, 16'h0020, 0);
    wait_done();
    check_run(8);
    checkOutput("level_after_basic", 64'(fifo_level), 0);

    // Descending.
    send_words(8, 0, 0, 32'h10);
    applyStimulus(8, 16'h0100, 1);
    wait_done();
    check_run(8);

    // Stall on empty buffer: one word every 3 cycles.
    stall_check = 1;
    applyStimulus(4, 16'h0200, 0);
    send_words(4, 2, 1, 0);
    wait_done();
    checkOutput("stall_write_count", 64'(run_writes), 4);
    stall_check = 0;

    // Zero-length chunk.
    applyStimulus(0, 16'h0300, 0);
    wait_done();
    checkOutput("zero_chunk_writes", 64'(run_writes), 0);

    // Address wrap.
    send_words(4, 0, 1, 0);
    applyStimulus(4, 16'hFFFE, 0);
    wait_done();

    // Start during writing is ignored.
    send_words(8, 0, 1, 0);
    applyStimulus(8, 16'h0040, 0);
    repeat (2) @(negedge clock);
    start = 1'b1; chunk_size = 16'd5; base_address = 16'h0999; descending = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();

    // Backpressure: 40 words offered while idle, buffer holds 32.
    fork
      send_words(40, 0, 1, 0);
    join_none
    repeat (40) @(negedge clock);
    checkOutput("full_ready", 64'(sif.ready), 0);
    checkOutput("full_level", 64'(fifo_level), 32);
    applyStimulus(40, 16'h0500, 0);
    wait fork;
    wait_done();
    checkOutput("level_after_full", 64'(fifo_level), 0);

    // Reset mid-writeback.
    send_words(8, 0, 1, 0);
    applyStimulus(8, 16'h0600, 0);
    begin
      int t = 0;
      while (run_writes < 3 && t < 100) begin
        @(posedge clock);
        t++;
      end
      if (t >= 100) reportFail("reset_run_timeout");
    end
    @(negedge clock);
    #1;
    reset = 1'b1;
    addr_q.delete();
    data_q.delete();
    pcyc_q.delete();
    exp_done = done_seen;
    @(negedge clock);
    checkOutput("midreset_write_enable", 64'(write_enable), 0);
    checkOutput("midreset_write_addr", 64'(write_addr), 0);
    checkOutput("midreset_write_data", 64'(write_data), 0);
    checkOutput("midreset_level", 64'(fifo_level), 0);
    checkOutput("midreset_busy", 64'(busy), 0);
    #1;
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("no_done_after_reset", 64'(done_seen), 64'(exp_done));
    send_words(8, 0, 0, 32'h10);
    applyStimulus(8, 16'h0020, 0);
    wait_done();
    check_run(8);

    // Randomized jobs with surplus words carried between runs.
    for (int it = 0; it < 10; it++) begin
      int chunk, extra, gap, lead;
      logic [15:0] base;
      bit desc;
      chunk = $urandom_range(1, 20);
      extra = (data_q.size() > 12) ? 0 : $urandom_range(0, 3);
      gap   = $urandom_range(0, 2);
      lead  = $urandom_range(0, 5);
      base  = 16'($urandom);
      desc  = 1'($urandom_range(0, 1));
      fork
        send_words(chunk + extra, gap, 1, 0);
      join_none
      repeat (lead) @(negedge clock);
      applyStimulus(chunk, base, desc);
      wait fork;
      wait_done();
      repeat (2) @(negedge clock);
      checkOutput("random_level", 64'(fifo_level), 64'(data_q.size()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
